// File: rtl/time_pkg.sv
// Elaboration-time helpers that convert between clock frequency, durations and cycle counts.
package time_pkg;

  // Clock cycles in time_ns at freq_mhz (truncating).
  function automatic longint unsigned nb_clk_for_time(input longint unsigned freq_mhz,
                                                      input longint unsigned time_ns);
    return (freq_mhz * time_ns) / 64'd1000;
  endfunction

  // One clock period in picoseconds (truncating); 0 MHz yields 0.
  function automatic longint unsigned ps_period_for_freq_mz(input longint unsigned freq_mhz);
    return (freq_mhz == 64'd0) ? 64'd0 : 64'd1000000 / freq_mhz;
  endfunction

endpackage

// File: rtl/multi_channel_timebase_if.sv
// Period-configuration port of multi_channel_timebase: one write per valid/ready transfer.
interface multi_channel_timebase_if #(
  parameter int NB_CHANNELS = 4,
  parameter int CNT_WIDTH   = 32
);
  localparam int CH_W = (NB_CHANNELS > 1) ? $clog2(NB_CHANNELS) : 1;

  // A write transfers on a rising edge where cfg_valid && cfg_ready; the master keeps
  // cfg_ch/cfg_period_clk stable while cfg_valid is high and has not yet been accepted.
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [CH_W-1:0]      cfg_ch;
  logic [CNT_WIDTH-1:0] cfg_period_clk;
  logic                 cfg_err;

  modport master (output cfg_valid, cfg_ch, cfg_period_clk, input cfg_ready, cfg_err);
  modport slave  (input cfg_valid, cfg_ch, cfg_period_clk, output cfg_ready, cfg_err);
endinterface

// File: rtl/multi_channel_timebase.sv
// NB_CHANNELS independent periodic / one-shot tick generators with a run-time period port.
// Define TIMEBASE_TIMESTAMP_EN to add the free-running timestamp_ps output.
module multi_channel_timebase #(
  parameter int CLK_FREQ_MHZ      = 100,
  parameter int NB_CHANNELS       = 4,
  parameter int CNT_WIDTH         = 32,
  parameter int DEFAULT_PERIOD_NS = 1000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NB_CHANNELS-1:0]   ch_start,
  input  logic [NB_CHANNELS-1:0]   ch_stop,
  input  logic [NB_CHANNELS-1:0]   ch_oneshot,
  multi_channel_timebase_if.slave  cfg,
  output logic [NB_CHANNELS-1:0]   ch_tick,
  output logic [NB_CHANNELS-1:0]   ch_busy,
  output logic [NB_CHANNELS-1:0]   ch_done
`ifdef TIMEBASE_TIMESTAMP_EN
  ,
  output logic [63:0]              timestamp_ps
`endif
);
  localparam int CH_W = (NB_CHANNELS > 1) ? $clog2(NB_CHANNELS) : 1;
  localparam longint unsigned DEF_RAW =
    time_pkg::nb_clk_for_time(64'(CLK_FREQ_MHZ), 64'(DEFAULT_PERIOD_NS));
  localparam logic [CNT_WIDTH-1:0] DEFAULT_CLK = CNT_WIDTH'((DEF_RAW == 64'd0) ? 64'd1 : DEF_RAW);
  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e               state_q  [NB_CHANNELS];
  state_e               state_d  [NB_CHANNELS];
  logic [CNT_WIDTH-1:0] cnt_q    [NB_CHANNELS];
  logic [CNT_WIDTH-1:0] cnt_d    [NB_CHANNELS];
  logic [CNT_WIDTH-1:0] period_q [NB_CHANNELS];
  logic [CNT_WIDTH-1:0] load     [NB_CHANNELS];
  logic [NB_CHANNELS-1:0] mode_q, mode_d, done_q, done_d;

  logic                 ready_q, pend_q, err_q, accept;
  logic [CH_W-1:0]      hold_ch_q;
  logic [CNT_WIDTH-1:0] hold_period_q;

  assign accept         = cfg.cfg_valid & ready_q;
  assign cfg.cfg_ready  = ready_q;
  assign cfg.cfg_err    = err_q;
  assign ch_done        = done_q;

  // Accepted writes sit in the holding register for one cycle and commit on the next edge,
  // which is also why ready drops for exactly that cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ready_q       <= 1'b0;
      pend_q        <= 1'b0;
      err_q         <= 1'b0;
      hold_ch_q     <= '0;
      hold_period_q <= '0;
      for (int i = 0; i < NB_CHANNELS; i++) period_q[i] <= DEFAULT_CLK;
    end else begin
      ready_q <= ~accept;
      pend_q  <= accept;
      err_q   <= 1'b0;
      if (accept) begin
        hold_ch_q     <= cfg.cfg_ch;
        hold_period_q <= cfg.cfg_period_clk;
      end
      if (pend_q) begin
        if (int'(hold_ch_q) < NB_CHANNELS) period_q[hold_ch_q] <= hold_period_q;
        else                               err_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NB_CHANNELS; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      mode_q <= '0;
      done_q <= '0;
    end else begin
      for (int i = 0; i < NB_CHANNELS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      mode_q <= mode_d;
      done_q <= done_d;
    end
  end

  // Stop overrides everything (including a coinciding expiry); start re-arms after an expiry.
  always_comb begin
    mode_d  = mode_q;
    done_d  = done_q;
    ch_tick = '0;
    ch_busy = '0;
    for (int i = 0; i < NB_CHANNELS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      load[i]    = (period_q[i] == '0) ? '0 : period_q[i] - ONE;
      ch_busy[i] = (state_q[i] == RUN);
      if (ch_stop[i]) begin
        state_d[i] = IDLE;
      end else begin
        if (state_q[i] == RUN) begin
          if (cnt_q[i] == '0) begin
            ch_tick[i] = 1'b1;
            if (mode_q[i]) begin
              state_d[i] = IDLE;
              done_d[i]  = 1'b1;
            end else begin
              cnt_d[i] = load[i];
            end
          end else begin
            cnt_d[i] = cnt_q[i] - ONE;
          end
        end
        if (ch_start[i]) begin
          state_d[i] = RUN;
          cnt_d[i]   = load[i];
          mode_d[i]  = ch_oneshot[i];
          done_d[i]  = 1'b0;
        end
      end
    end
  end

`ifdef TIMEBASE_TIMESTAMP_EN
  localparam logic [63:0] PS_STEP = 64'(time_pkg::ps_period_for_freq_mz(64'(CLK_FREQ_MHZ)));

  always_ff @(posedge clk) begin
    if (!rst_n) timestamp_ps <= '0;
    else        timestamp_ps <= timestamp_ps + PS_STEP;
  end
`endif

endmodule

// File: tb/tb_multi_channel_timebase.sv
// Self-checking bench for multi_channel_timebase: tick scoreboard, vector table, corner sequences.
module tb_multi_channel_timebase;
  localparam int NB      = 5;
  localparam int CW      = 32;
  localparam int CH_W    = 3;
  localparam int DEF_CLK = 100;  // 100 MHz * 1000 ns

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NB-1:0] ch_start = '0, ch_stop = '0, ch_oneshot = '0;
  logic [NB-1:0] ch_tick, ch_busy, ch_done;
`ifdef TIMEBASE_TIMESTAMP_EN
  logic [63:0] timestamp_ps;
`endif

  multi_channel_timebase_if #(.NB_CHANNELS(NB), .CNT_WIDTH(CW)) cfg ();

  multi_channel_timebase #(
    .CLK_FREQ_MHZ(100), .NB_CHANNELS(NB), .CNT_WIDTH(CW), .DEFAULT_PERIOD_NS(1000)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ch_start(ch_start), .ch_stop(ch_stop), .ch_oneshot(ch_oneshot),
    .cfg(cfg),
    .ch_tick(ch_tick), .ch_busy(ch_busy), .ch_done(ch_done)
`ifdef TIMEBASE_TIMESTAMP_EN
    , .timestamp_ps(timestamp_ps)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [35:0] exp_q[$];  // {channel, edge index}

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_tick(input int c, input int e);
    exp_q.push_back({4'(c), 32'(e)});
  endtask

  // A tick seen in the cycle after edge cyc is sampled at edge cyc+1.
  always @(negedge clk) begin
    int k;
    k = cyc + 1;
    while (exp_q.size() > 0 && int'(exp_q[0][31:0]) < k) begin
      n_checks++;
      n_fail++;
      $display("FAIL tick_missed: ch %0d edge %0d got no tick, required a tick",
               exp_q[0][35:32], exp_q[0][31:0]);
      void'(exp_q.pop_front());
    end
    for (int c = 0; c < NB; c++) begin
      if (ch_tick[c] === 1'b1) begin
        n_checks++;
        if (exp_q.size() > 0 && exp_q[0] == {4'(c), 32'(k)}) void'(exp_q.pop_front());
        else begin
          n_fail++;
          $display("FAIL tick_unexpected: ch %0d edge %0d got a tick, required none", c, k);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [NB-1:0] bit_of(input int c);
    return NB'(1) << c;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Park so that the next driven value is sampled at edge e.
  task automatic goto_edge(input int e);
    while (cyc < e - 1) step(1);
  endtask

  task automatic drive(input logic [NB-1:0] st, input logic [NB-1:0] sp,
                       input logic [NB-1:0] os, output int e);
    ch_start = st; ch_stop = sp; ch_oneshot = os;
    step(1);
    e = cyc;
    ch_start = '0; ch_stop = '0; ch_oneshot = '0;
  endtask

  // Returns right after the accepting edge.
  task automatic cfg_write(input int c, input int p);
    int w;
    w = 0;
    while (cfg.cfg_ready !== 1'b1 && w < 8) begin
      step(1);
      w++;
    end
    chk("cfg_ready_wait", 64'(cfg.cfg_ready), 64'd1);
    cfg.cfg_valid = 1'b1;
    cfg.cfg_ch = CH_W'(c);
    cfg.cfg_period_clk = CW'(p);
    step(1);
    cfg.cfg_valid = 1'b0;
  endtask

  typedef struct {
    int   ch;
    int   period;
    logic oneshot;
    int   n_ticks;
    logic exp_busy;
    logic exp_done;
  } vec_t;
  vec_t vecs[6];

  task automatic run_vec(input vec_t v);
    int t, p;
    cfg_write(v.ch, v.period);
    step(1);
    chk("vec_cfg_err", 64'(cfg.cfg_err), 64'd0);
    chk("vec_cfg_ready", 64'(cfg.cfg_ready), 64'd1);
    drive(bit_of(v.ch), '0, v.oneshot ? bit_of(v.ch) : '0, t);
    chk("vec_busy_start", 64'(ch_busy[v.ch]), 64'd1);
    chk("vec_done_start", 64'(ch_done[v.ch]), 64'd0);
    p = (v.period == 0) ? 1 : v.period;
    for (int k = 1; k <= v.n_ticks; k++) push_tick(v.ch, t + p * k);
    goto_edge(t + p * v.n_ticks + 1);
    chk("vec_busy_end", 64'(ch_busy[v.ch]), 64'(v.exp_busy));
    chk("vec_done_end", 64'(ch_done[v.ch]), 64'(v.exp_done));
    if (!v.oneshot) begin
      drive('0, bit_of(v.ch), '0, t);
      chk("vec_busy_stop", 64'(ch_busy[v.ch]), 64'd0);
    end
    chk("vec_drain", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int t, t2;
    cfg.cfg_valid = 1'b0;
    cfg.cfg_ch = '0;
    cfg.cfg_period_clk = '0;

    vecs[0] = '{ch: 4, period: 7, oneshot: 1'b1, n_ticks: 1, exp_busy: 1'b0, exp_done: 1'b1};
    vecs[1] = '{ch: 1, period: 5, oneshot: 1'b1, n_ticks: 1, exp_busy: 1'b0, exp_done: 1'b1};
    vecs[2] = '{ch: 3, period: 0, oneshot: 1'b0, n_ticks: 4, exp_busy: 1'b1, exp_done: 1'b0};
    vecs[3] = '{ch: 2, period: 1, oneshot: 1'b0, n_ticks: 3, exp_busy: 1'b1, exp_done: 1'b0};
    vecs[4] = '{ch: 0, period: 3, oneshot: 1'b0, n_ticks: 3, exp_busy: 1'b1, exp_done: 1'b0};
    vecs[5] = '{ch: 3, period: 2, oneshot: 1'b1, n_ticks: 1, exp_busy: 1'b0, exp_done: 1'b1};

    // Reset state, then ready in the first cycle after reset.
    step(3);
    chk("rst_ready", 64'(cfg.cfg_ready), 64'd0);
    chk("rst_err", 64'(cfg.cfg_err), 64'd0);
    chk("rst_busy", 64'(ch_busy), 64'd0);
    chk("rst_done", 64'(ch_done), 64'd0);
    chk("rst_tick", 64'(ch_tick), 64'd0);
`ifdef TIMEBASE_TIMESTAMP_EN
    chk("rst_ts", timestamp_ps, 64'd0);
`endif
    rst_n = 1'b1;
    step(1);
    chk("post_rst_ready", 64'(cfg.cfg_ready), 64'd1);
`ifdef TIMEBASE_TIMESTAMP_EN
    step(9);
    chk("ts_10_cycles", timestamp_ps, 64'd100000);
`endif

    // Default period: ch0 periodic ticks every DEF_CLK cycles.
    drive(bit_of(0), '0, '0, t);
    for (int k = 1; k <= 3; k++) push_tick(0, t + DEF_CLK * k);
    goto_edge(t + 3 * DEF_CLK + 1);
    drive('0, bit_of(0), '0, t2);
    chk("def_busy_stop", 64'(ch_busy[0]), 64'd0);
    chk("def_drain", 64'(exp_q.size()), 64'd0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Start and stop in the same cycle while running: stop wins, no tick.
    cfg_write(0, 10);
    step(1);
    drive(bit_of(0), '0, '0, t);
    goto_edge(t + 4);
    drive(bit_of(0), bit_of(0), '0, t2);
    chk("startstop_busy", 64'(ch_busy[0]), 64'd0);
    goto_edge(t + 16);
    chk("startstop_done", 64'(ch_done[0]), 64'd0);
    chk("startstop_drain", 64'(exp_q.size()), 64'd0);

    // Period rewrite mid-count applies only from the next reload.
    cfg_write(2, 8);
    step(1);
    drive(bit_of(2), '0, '0, t);
    push_tick(2, t + 8);
    goto_edge(t + 3);
    cfg_write(2, 3);
    push_tick(2, t + 11);
    push_tick(2, t + 14);
    goto_edge(t + 15);
    drive('0, bit_of(2), '0, t2);
    chk("rewrite_busy_stop", 64'(ch_busy[2]), 64'd0);
    chk("rewrite_drain", 64'(exp_q.size()), 64'd0);

    // Out-of-range channels: err pulse at commit, ready low one cycle, periods untouched.
    cfg_write(5, 2);
    chk("oor_ready_low", 64'(cfg.cfg_ready), 64'd0);
    chk("oor_err_early", 64'(cfg.cfg_err), 64'd0);
    step(1);
    chk("oor_ready_back", 64'(cfg.cfg_ready), 64'd1);
    chk("oor_err_pulse", 64'(cfg.cfg_err), 64'd1);
    step(1);
    chk("oor_err_clear", 64'(cfg.cfg_err), 64'd0);
    cfg_write(7, 2);
    step(1);
    chk("oor7_err_pulse", 64'(cfg.cfg_err), 64'd1);
    step(1);
    drive(bit_of(4), '0, bit_of(4), t);
    push_tick(4, t + 7);
    goto_edge(t + 8);
    chk("oor_period_kept", 64'(ch_done[4]), 64'd1);
    chk("oor_drain", 64'(exp_q.size()), 64'd0);

    // Start coinciding with one-shot expiry: tick emitted, re-armed, done stays 0.
    drive(bit_of(1), '0, bit_of(1), t);
    push_tick(1, t + 5);
    goto_edge(t + 5);
    drive(bit_of(1), '0, bit_of(1), t2);
    chk("rearm_exp_busy", 64'(ch_busy[1]), 64'd1);
    chk("rearm_exp_done", 64'(ch_done[1]), 64'd0);
    push_tick(1, t + 10);
    goto_edge(t + 11);
    chk("rearm_exp_busy_end", 64'(ch_busy[1]), 64'd0);
    chk("rearm_exp_done_end", 64'(ch_done[1]), 64'd1);

    // Stop while idle leaves done untouched.
    drive('0, bit_of(1), '0, t2);
    chk("idle_stop_busy", 64'(ch_busy[1]), 64'd0);
    chk("idle_stop_done", 64'(ch_done[1]), 64'd1);

    // Re-arm a running periodic channel: count restarts from the re-arm edge.
    cfg_write(3, 6);
    step(1);
    drive(bit_of(3), '0, '0, t);
    chk("rearm_clears_done", 64'(ch_done[3]), 64'd0);
    goto_edge(t + 3);
    drive(bit_of(3), '0, '0, t2);
    push_tick(3, t2 + 6);
    push_tick(3, t2 + 12);
    goto_edge(t2 + 13);
    drive('0, bit_of(3), '0, t);
    chk("rearm_busy_stop", 64'(ch_busy[3]), 64'd0);
    chk("rearm_drain", 64'(exp_q.size()), 64'd0);

    // Reset mid-count with a pending out-of-range write: everything back to reset state.
    drive(bit_of(0), '0, '0, t);
    step(2);
    cfg.cfg_valid = 1'b1;
    cfg.cfg_ch = CH_W'(7);
    cfg.cfg_period_clk = CW'(2);
    step(1);
    cfg.cfg_valid = 1'b0;
    rst_n = 1'b0;
    step(1);
    chk("midrst_err", 64'(cfg.cfg_err), 64'd0);
    chk("midrst_ready", 64'(cfg.cfg_ready), 64'd0);
    chk("midrst_busy", 64'(ch_busy), 64'd0);
    chk("midrst_done", 64'(ch_done), 64'd0);
    step(1);
    rst_n = 1'b1;
    step(1);
    chk("midrst_ready_back", 64'(cfg.cfg_ready), 64'd1);
    chk("midrst_err_after", 64'(cfg.cfg_err), 64'd0);
    drive(bit_of(0), '0, '0, t);
    push_tick(0, t + DEF_CLK);
    goto_edge(t + DEF_CLK + 1);
    drive('0, bit_of(0), '0, t2);
    chk("midrst_default_period", 64'(ch_busy[0]), 64'd0);
    step(3);
    chk("final_drain", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
